// File: rtl/neuron_accumulator_if.sv
// Product input stream and activation output stream of one neuron accumulator.
interface neuron_accumulator_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          product;
  logic                 in_neg;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid, product, in_neg, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, product, in_neg, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/neuron_accumulator.sv
// Signed saturating accumulator of sign-magnitude weighted products plus bias,
// followed by shift, ReLU and output clamp; one activation per neuron.
module neuron_accumulator #(
  parameter int N_INPUTS  = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SHIFT     = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [15:0] bias,
  output logic        busy,
  neuron_accumulator_if.slave io
);
  typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} state_t;

  localparam logic [7:0]                  LAST    = 8'(N_INPUTS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0]        OUT_MAX = {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  state_t                      state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [7:0]                  count;
  logic [OUT_WIDTH-1:0]        out_q;
  logic                        accept;
  logic signed [ACC_WIDTH:0]   prod_ext;
  logic signed [ACC_WIDTH:0]   sum_ext;
  logic signed [ACC_WIDTH-1:0] acc_sat;
  logic [ACC_WIDTH-1:0]        shifted;
  logic [OUT_WIDTH-1:0]        act_val;

  // Handshake outputs decode directly from state.
  assign io.in_ready  = (state == ACCUM);
  assign io.out_valid = (state == OUT);
  assign io.out_data  = out_q;
  assign busy         = (state != IDLE);
  assign accept       = io.in_valid & io.in_ready;

  // One extra guard bit exposes overflow; clamp instead of wrapping.
  always_comb begin
    prod_ext = {{(ACC_WIDTH-15){1'b0}}, io.product};
    sum_ext  = io.in_neg ? ({acc[ACC_WIDTH-1], acc} - prod_ext)
                         : ({acc[ACC_WIDTH-1], acc} + prod_ext);
    acc_sat  = sum_ext[ACC_WIDTH-1:0];
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1])
      acc_sat = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  // ReLU, scale, then clamp to the unsigned output range.
  always_comb begin
    shifted = acc >>> SHIFT;
    act_val = '0;
    if (!acc[ACC_WIDTH-1])
      act_val = (shifted > OUT_MAX) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && count == LAST) state_nxt = ACT;
      ACT:     state_nxt = OUT;
      OUT:     if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load bias, accumulate accepted products, capture activation.
  always_ff @(posedge clock) begin
    if (clear) begin
      acc   <= '0;
      count <= '0;
      out_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          acc   <= $signed({{(ACC_WIDTH-16){1'b0}}, bias});
          count <= '0;
        end
        ACCUM: if (accept) begin
          acc   <= acc_sat;
          count <= count + 8'd1;
        end
        ACT:     out_q <= act_val;
        default: ;
      endcase
    end
  end
endmodule
